// File: rtl/pfstride_gen_pkg.sv
// Shared types for the stride prefetch generator: prefetch op, table entry, level codes.
// Helper functions for confidence saturation and signed-12-bit range test.
package pfstride_gen_pkg;

  localparam int PADDR_W = 50;
  localparam int DELTA_W = 12;
  localparam int LVL_W   = 2;
  localparam int PC_W    = 16;
  localparam int TAG_W   = 6;
  localparam int CONF_W  = 2;

  localparam logic [LVL_W-1:0] PF_LVL_DC = 2'd0;
  localparam logic [LVL_W-1:0] PF_LVL_L2 = 2'd1;

  typedef struct packed {
    logic [PADDR_W-1:0]        paddr;
    logic signed [DELTA_W-1:0] delta;
    logic [LVL_W-1:0]          level;
  } I_pfgtopfe_op_type;

  typedef struct packed {
    logic               v;
    logic [TAG_W-1:0]   tag;
    logic [PADDR_W-1:0] last_paddr;
    logic [DELTA_W-1:0] stride;
    logic [CONF_W-1:0]  conf;
  } stride_ent_t;

  function automatic logic [CONF_W-1:0] sat_inc(input logic [CONF_W-1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [CONF_W-1:0] sat_dec(input logic [CONF_W-1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  // A 50-bit difference fits signed 12 bits when bits [49:11] are all equal.
  function automatic logic fits_s12(input logic [PADDR_W-1:0] d);
    return (&d[PADDR_W-1:DELTA_W-1]) || ~(|d[PADDR_W-1:DELTA_W-1]);
  endfunction

endpackage

// File: rtl/pfstride_gen_if.sv
// Training-event channel from the core and prefetch-op channel to the engine.
// master drives events and op retry; slave (the generator) drives event retry and ops.
interface pfstride_gen_if;
  import pfstride_gen_pkg::*;

  logic                 coretopfg_ld_valid;
  logic                 coretopfg_ld_retry;
  logic [PC_W-1:0]      coretopfg_ld_pc;
  logic [PADDR_W-1:0]   coretopfg_ld_paddr;
  logic                 pfgtopfe_op_valid;
  logic                 pfgtopfe_op_retry;
  I_pfgtopfe_op_type    pfgtopfe_op;

  modport master (
    output coretopfg_ld_valid, coretopfg_ld_pc, coretopfg_ld_paddr, pfgtopfe_op_retry,
    input  coretopfg_ld_retry, pfgtopfe_op_valid, pfgtopfe_op
  );

  modport slave (
    input  coretopfg_ld_valid, coretopfg_ld_pc, coretopfg_ld_paddr, pfgtopfe_op_retry,
    output coretopfg_ld_retry, pfgtopfe_op_valid, pfgtopfe_op
  );

endinterface

// File: rtl/pfstride_gen_pfq2.sv
// 2-entry shift FIFO, head on out_dat; push and pop in one cycle both take effect.
// Latency: pushed data visible on out_vld/out_dat the cycle after the push edge.
// Backpressure: full when 2 entries held; push while full is only honoured with a pop.
module pfstride_gen_pfq2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         full,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic [1:0]   cnt;
  logic [W-1:0] m0, m1;
  logic         push, pop;

  assign full    = (cnt == 2'd2);
  assign out_vld = (cnt != 2'd0);
  assign out_dat = m0;
  assign pop     = out_vld && out_rdy;
  assign push    = in_vld && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      m0  <= '0;
      m1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) m0 <= in_dat;
          else             m1 <= in_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          m0  <= m1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            m0 <= in_dat;
          end else begin
            m0 <= m1;
            m1 <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pfstride_gen.sv
// PC-indexed stride table; trains on accepted loads and emits confident stride prefetches.
// Latency: op visible 1 cycle after the accepting edge when the output queue is empty.
// Backpressure: load events are retried while the 2-entry op queue is full and not popping.
module pfstride_gen
  import pfstride_gen_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int CONF_TH = 2
) (
  input logic           clk,
  input logic           reset,
  pfstride_gen_if.slave bus
);

  localparam int               IDX_W     = $clog2(ENTRIES);
  localparam logic [CONF_W-1:0] CONF_TH_L = CONF_TH[CONF_W-1:0];

  stride_ent_t tbl [ENTRIES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   ld_tag;
  stride_ent_t        ent, ent_nxt;
  logic [PADDR_W-1:0] d;
  logic               hit, d_ok, match, accept, issue, q_full;
  logic [CONF_W-1:0]  conf_nxt;
  I_pfgtopfe_op_type  op_nxt;
  logic [63:0]        op_head;
  logic               unused_pc_bits;

  assign idx    = bus.coretopfg_ld_pc[IDX_W+1:2];
  assign ld_tag = bus.coretopfg_ld_pc[PC_W-1:10];
  assign unused_pc_bits = ^{bus.coretopfg_ld_pc[1:0], bus.coretopfg_ld_pc[9:IDX_W+2]};

  // The table is written on the accepting edge, so a following event to the
  // same entry reads the updated stride/conf with no extra bypass path.
  assign ent   = tbl[idx];
  assign hit   = ent.v && (ent.tag == ld_tag);
  assign d     = bus.coretopfg_ld_paddr - ent.last_paddr;
  assign d_ok  = fits_s12(d) && (d != '0);
  assign match = hit && d_ok && (d[DELTA_W-1:0] == ent.stride);

  assign bus.coretopfg_ld_retry = q_full && bus.pfgtopfe_op_retry;
  assign accept = bus.coretopfg_ld_valid && !bus.coretopfg_ld_retry;

  always_comb begin
    ent_nxt  = ent;
    conf_nxt = match ? sat_inc(ent.conf) : sat_dec(ent.conf);
    if (!hit) begin
      ent_nxt = '{v: 1'b1, tag: ld_tag, last_paddr: bus.coretopfg_ld_paddr,
                  stride: '0, conf: '0};
    end else begin
      ent_nxt.last_paddr = bus.coretopfg_ld_paddr;
      ent_nxt.conf       = conf_nxt;
      if (!match) ent_nxt.stride = d_ok ? d[DELTA_W-1:0] : '0;
    end
  end

  always_comb begin
    op_nxt       = '0;
    op_nxt.paddr = bus.coretopfg_ld_paddr + {{(PADDR_W-DELTA_W){ent.stride[DELTA_W-1]}}, ent.stride};
    op_nxt.delta = ent.stride;
    op_nxt.level = (conf_nxt == 2'd3) ? PF_LVL_DC : PF_LVL_L2;
  end

  assign issue = accept && match && (conf_nxt >= CONF_TH_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (accept) begin
      tbl[idx] <= ent_nxt;
    end
  end

  pfstride_gen_pfq2 #(.W(64)) u_pfq2 (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (issue),
    .in_dat  (op_nxt),
    .full    (q_full),
    .out_vld (bus.pfgtopfe_op_valid),
    .out_rdy (!bus.pfgtopfe_op_retry),
    .out_dat (op_head)
  );

  assign bus.pfgtopfe_op = op_head;

endmodule
